// File: rtl/proc_control.sv
// Control FSM for a simple bus-based processor: decodes mv/mvi/add/sub and sequences
// the register, ALU and bus enables over states T0..T3.
module proc_control (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Run,
    input  logic [8:0] IR,
    output logic       IRin,
    output logic [7:0] Rin,
    output logic [7:0] Rout,
    output logic       DINout,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic       AddSub,
    output logic       Done
);

    typedef enum logic [1:0] {StT0, StT1, StT2, StT3} state_e;

    localparam logic [2:0] OpMv  = 3'b000;
    localparam logic [2:0] OpMvi = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpSub = 3'b011;

    state_e     state_q, state_d;
    logic [2:0] opcode;
    logic [7:0] x_onehot;
    logic [7:0] y_onehot;
    logic       is_addsub;

    assign opcode    = IR[8:6];
    assign x_onehot  = 8'd1 << IR[5:3];
    assign y_onehot  = 8'd1 << IR[2:0];
    assign is_addsub = (opcode == OpAdd) || (opcode == OpSub);

    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            state_q <= StT0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StT0;
        IRin    = 1'b0;
        Rin     = 8'h00;
        Rout    = 8'h00;
        DINout  = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        AddSub  = 1'b0;
        Done    = 1'b0;
        // Outputs are held quiet while reset is asserted so IRin cannot follow Run.
        if (!Resetn) begin
            unique case (state_q)
                StT0: begin
                    IRin    = Run;
                    state_d = Run ? StT1 : StT0;
                end
                StT1: begin
                    case (opcode)
                        OpMv: begin
                            Rout = y_onehot;
                            Rin  = x_onehot;
                            Done = 1'b1;
                        end
                        OpMvi: begin
                            DINout = 1'b1;
                            Rin    = x_onehot;
                            Done   = 1'b1;
                        end
                        OpAdd, OpSub: begin
                            Rout    = x_onehot;
                            Ain     = 1'b1;
                            state_d = StT2;
                        end
                        default: Done = 1'b1;
                    endcase
                end
                StT2: begin
                    if (is_addsub) begin
                        Rout    = y_onehot;
                        Gin     = 1'b1;
                        AddSub  = (opcode == OpSub);
                        state_d = StT3;
                    end
                end
                StT3: begin
                    if (is_addsub) begin
                        Gout = 1'b1;
                        Rin  = x_onehot;
                        Done = 1'b1;
                    end
                end
                default: state_d = StT0;
            endcase
        end
    end

endmodule

// File: doc/proc_control.md
PROC_CONTROL -- requirements
Module: proc_control

Interface
REQ-001 SHALL provide port: Clock  in  1  system clock; state advances on rising edge.
REQ-002 SHALL provide port: Resetn  in  1  reset, asynchronous, active-high (name kept per codebase convention; 1 = reset).
REQ-003 SHALL provide port: Run  in  1  start request; sampled only in state T0.
REQ-004 SHALL provide port: IR  in  9  current instruction III_XXX_YYY (opcode, dest reg X, src reg Y), from external IR register.
REQ-005 SHALL provide port: IRin  out  1  load enable for instruction register.
REQ-006 SHALL provide port: Rin  out  8  one-hot load enables for registers R0..R7.
REQ-007 SHALL provide port: Rout  out  8  one-hot bus drive enables for R0..R7.
REQ-008 SHALL provide port: DINout  out  1  drive external data input onto bus.
REQ-009 SHALL provide port: Ain  out  1  load enable for ALU operand register A.
REQ-010 SHALL provide port: Gin  out  1  load enable for ALU result register G.
REQ-011 SHALL provide port: Gout  out  1  drive G onto bus.
REQ-012 SHALL provide port: AddSub  out  1  ALU op select, 0 = add, 1 = subtract.
REQ-013 SHALL provide port: Done  out  1  instruction complete, high for exactly one cycle.

Function
REQ-014 SHALL implement a 4-state FSM T0, T1, T2, T3, state register updated on rising Clock.
REQ-015 SHALL decode opcode III: 000 = mv Rx,Ry; 001 = mvi Rx,#D; 010 = add Rx,Ry; 011 = sub Rx,Ry; 100-111 = undefined (NOP).
REQ-016 SHALL produce all outputs combinationally from current state and IR; all outputs 0 unless listed below.
REQ-017 T0: IRin = Run; next = T1 if Run = 1, else stay T0.
REQ-018 T1, mv: Rout[Y] = 1, Rin[X] = 1, Done = 1; next T0.
REQ-019 T1, mvi: DINout = 1, Rin[X] = 1, Done = 1; next T0.
REQ-020 T1, add/sub: Rout[X] = 1, Ain = 1; next T2.
REQ-021 T1, undefined: Done = 1, no enables; next T0.
REQ-022 T2, add/sub: Rout[Y] = 1, Gin = 1, AddSub = 1 for sub, 0 for add; next T3.
REQ-023 T3, add/sub: Gout = 1, Rin[X] = 1, Done = 1; next T0.
REQ-024 Latency from Run sampled in T0: mv/mvi/NOP = 2 cycles (Done in T1); add/sub = 4 cycles (Done in T3).
REQ-025 At most one bus driver (Rout bits, DINout, Gout) SHALL be high in any cycle; Rin and Rout each at most one-hot.
REQ-026 Run SHALL be ignored in T1-T3; Run held high SHALL start the next fetch in the T0 cycle immediately after Done.
REQ-027 X = Y (e.g. add R3,R3) SHALL be legal and produce the same sequence with identical indices.
REQ-028 IR changes outside T0 SHALL be assumed stable by the caller; controller decodes live IR each cycle.
REQ-029 States T2/T3 reached with a non-add/sub opcode (illegal) SHALL drive no enables and return to T0.

Reset
REQ-030 Resetn = 1 SHALL force state to T0 immediately, independent of Clock.
REQ-031 During reset all outputs SHALL be 0, including IRin regardless of Run.
REQ-032 Reset mid-instruction SHALL abort it with no further Rin/Gin/Ain pulses; after release, operation resumes from T0.

Verification
REQ-033 Reset: assert Resetn mid-T2 of add -> state T0 same cycle, all outputs 0, Done never asserted for that instruction.
REQ-034 mvi: IR = 001_010_000, Run = 1 -> T0 IRin = 1; T1 DINout = 1, Rin = 8'b00000100, Done = 1; back to T0.
REQ-035 mv: IR = 000_001_110 -> T1 Rout = 8'b01000000, Rin = 8'b00000010, Done = 1.
REQ-036 sub: IR = 011_000_111 -> T1 Rout = 8'h01, Ain = 1; T2 Rout = 8'h80, Gin = 1, AddSub = 1; T3 Gout = 1, Rin = 8'h01, Done = 1.
REQ-037 Back-to-back: Run held 1 across add then mv -> IRin in T0 directly after add's T3; Done pulses exactly at cycles 4 and 6.
REQ-038 Undefined opcode 111 and Run = 0 idle: NOP gives Done in T1 with no enables; Run = 0 keeps T0 with all outputs 0 for 10 cycles.
